// File: rtl/multi_reg_file_if.sv
// ---------------------------------------------------------------------------
// Module  : multi_reg_file_if
// Purpose : Core data-bus bundle between the control unit and multi_reg_file.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface multi_reg_file_if #(
  parameter int REG_COUNT = 11,
  parameter int REG_WIDTH = 12
);
  logic [REG_COUNT-1:0] read_en;
  logic [REG_COUNT-1:0] write_en;
  logic [REG_COUNT-1:0] inc_en;
  logic                 acc_en;
  logic                 clr_ovf;
  logic [REG_WIDTH-1:0] datain;
  logic [REG_WIDTH-1:0] dataout;
  logic                 read_err;
  logic                 acc_ovf;

  modport master (
    output read_en, write_en, inc_en, acc_en, clr_ovf, datain,
    input  dataout, read_err, acc_ovf
  );

  modport slave (
    input  read_en, write_en, inc_en, acc_en, clr_ovf, datain,
    output dataout, read_err, acc_ovf
  );
endinterface

`default_nettype wire

// File: rtl/multi_reg_file.sv
// ---------------------------------------------------------------------------
// Module  : multi_reg_file
// Purpose : Per-core register file with lowest-index write/increment,
//           accumulate-into-Total with sticky overflow, and read checking.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module multi_reg_file #(
  parameter int REG_COUNT   = 11,
  parameter int REG_WIDTH   = 12,
  parameter int CORE_NUMBER = 0,
  parameter int TOTAL_IDX   = 10,
  parameter int DEFAULT_IDX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  multi_reg_file_if.slave       bus
);

  localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  logic [REG_WIDTH-1:0] regs_q [REG_COUNT];
  logic [REG_WIDTH-1:0] regs_d [REG_COUNT];
  logic                 acc_ovf_q, acc_ovf_d;

  logic [IDX_W-1:0]     wr_idx, inc_idx, rd_idx;
  logic [REG_WIDTH:0]   acc_sum;
  logic                 rd_onehot;

  // Lowest set bit wins: scan downwards so the last hit is the lowest index.
  always_comb begin
    wr_idx  = '0;
    inc_idx = '0;
    for (int i = REG_COUNT - 1; i >= 0; i--) begin
      if (bus.write_en[i]) wr_idx  = IDX_W'(i);
      if (bus.inc_en[i])   inc_idx = IDX_W'(i);
    end
  end

  assign acc_sum = {1'b0, regs_q[TOTAL_IDX]} + {1'b0, bus.datain};

  always_comb begin
    regs_d    = regs_q;
    acc_ovf_d = acc_ovf_q & ~bus.clr_ovf;
    if (bus.write_en != '0) begin
      regs_d[wr_idx] = bus.datain;
    end else if (bus.inc_en != '0) begin
      regs_d[inc_idx] = regs_q[inc_idx] + REG_WIDTH'(1);
    end else if (bus.acc_en) begin
      regs_d[TOTAL_IDX] = acc_sum[REG_WIDTH-1:0];
      // A carry out sets the flag even when clr_ovf is asserted this cycle.
      if (acc_sum[REG_WIDTH]) acc_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[TOTAL_IDX] <= REG_WIDTH'(CORE_NUMBER);
      acc_ovf_q         <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      acc_ovf_q <= acc_ovf_d;
    end
  end

  always_comb begin
    rd_onehot = (bus.read_en != '0) &&
                ((bus.read_en & (bus.read_en - REG_COUNT'(1))) == '0);
    rd_idx    = IDX_W'(DEFAULT_IDX);
    if (rd_onehot) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (bus.read_en[i]) rd_idx = IDX_W'(i);
      end
    end
  end

  assign bus.dataout  = regs_q[rd_idx];
  assign bus.read_err = ~rd_onehot;
  assign bus.acc_ovf  = acc_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_reg_file.sv
// ---------------------------------------------------------------------------
// Module  : tb_multi_reg_file
// Purpose : Scoreboard bench for multi_reg_file against an abstract model.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multi_reg_file;

  localparam int N    = 11;
  localparam int W    = 12;
  localparam int CORE = 3;
  localparam int TOT  = 10;
  localparam int DEF  = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  multi_reg_file_if #(.REG_COUNT(N), .REG_WIDTH(W)) bus ();

  multi_reg_file #(
    .REG_COUNT(N), .REG_WIDTH(W), .CORE_NUMBER(CORE),
    .TOTAL_IDX(TOT), .DEFAULT_IDX(DEF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [W-1:0] dout;
    logic         err;
    logic         ovf;
    bit           chk;
    int           cyc;
    string        tag;
  } exp_t;

  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  string phase = "init";

  // Reference state: plain integers, updated from the behavioural rules.
  int m_reg [N];
  bit m_ovf;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic step(input bit rst, input logic [N-1:0] rd, input logic [N-1:0] wr,
                      input logic [N-1:0] inc, input bit acc, input bit clr,
                      input int din, input bit chk = 1'b1);
    exp_t e;
    int   s;
    bit   nxt_ovf;
    @(posedge clk);
    #1;
    reset        = rst;
    bus.read_en  = rd;
    bus.write_en = wr;
    bus.inc_en   = inc;
    bus.acc_en   = acc;
    bus.clr_ovf  = clr;
    bus.datain   = W'(din);
    cyc++;
    // Expected bus view this cycle: state before the coming edge.
    if ($countones(rd) == 1) begin
      e.dout = W'(m_reg[lowest(rd)]);
      e.err  = 1'b0;
    end else begin
      e.dout = W'(m_reg[DEF]);
      e.err  = 1'b1;
    end
    e.ovf = m_ovf;
    e.chk = chk;
    e.cyc = cyc;
    e.tag = phase;
    sb_q.push_back(e);
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = 0;
      m_reg[TOT] = CORE % (1 << W);
      m_ovf      = 1'b0;
    end else begin
      nxt_ovf = m_ovf && !clr;
      if (wr != 0) begin
        m_reg[lowest(wr)] = din % (1 << W);
      end else if (inc != 0) begin
        m_reg[lowest(inc)] = (m_reg[lowest(inc)] + 1) % (1 << W);
      end else if (acc) begin
        s = m_reg[TOT] + (din % (1 << W));
        m_reg[TOT] = s % (1 << W);
        if (s >= (1 << W)) nxt_ovf = 1'b1;
      end
      m_ovf = nxt_ovf;
    end
  endtask

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Monitor: one expected entry per driven cycle, checked mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.chk) begin
        n_cmp++;
        if (bus.dataout !== e.dout || bus.read_err !== e.err || bus.acc_ovf !== e.ovf) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got dout=%h err=%b ovf=%b, expected dout=%h err=%b ovf=%b",
                   e.tag, e.cyc, bus.dataout, bus.read_err, bus.acc_ovf,
                   e.dout, e.err, e.ovf);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r_rd, r_wr, r_inc;
    foreach (m_reg[i]) m_reg[i] = 0;
    m_ovf        = 1'b0;
    reset        = 1'b1;
    bus.read_en  = '0;
    bus.write_en = '0;
    bus.inc_en   = '0;
    bus.acc_en   = 1'b0;
    bus.clr_ovf  = 1'b0;
    bus.datain   = '0;

    // Contents are unknown before the first reset edge.
    phase = "reset";
    step(1, oh(0), 0, 0, 0, 0, 0, 1'b0);
    step(1, oh(0), 0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < N; i++) step(0, oh(i), 0, 0, 0, 0, 0);

    phase = "write";
    step(0, 0, 11'h002, 0, 0, 0, 12'h0A5);
    step(0, 11'h002, 11'h006, 0, 0, 0, 12'h111);
    step(0, 11'h002, 0, 0, 0, 0, 0);
    step(0, 11'h004, 0, 0, 0, 0, 0);

    phase = "inc_wrap";
    step(0, 0, 11'h010, 0, 0, 0, 12'hFFE);
    for (int i = 0; i < 3; i++) step(0, 11'h010, 0, 11'h010, 0, 0, 0);
    step(0, 11'h010, 11'h010, 11'h010, 0, 0, 12'h050);
    step(0, 11'h010, 0, 0, 0, 0, 0);

    phase = "acc_ovf";
    step(0, 0, oh(TOT), 0, 0, 0, 12'hF00);
    step(0, oh(TOT), 0, 0, 1, 0, 12'h0FF);
    step(0, oh(TOT), 0, 0, 1, 0, 12'h002);
    step(0, oh(TOT), 0, 0, 1, 1, 12'hFFF);
    step(0, oh(TOT), 0, 0, 0, 1, 0);
    step(0, oh(TOT), oh(TOT), 0, 0, 0, 12'h7FF);
    step(0, oh(TOT), 0, 0, 1, 0, 12'h801);
    step(0, oh(TOT), oh(TOT), 0, 0, 0, 12'h000);
    step(0, oh(TOT), 0, 0, 0, 0, 0);

    phase = "illegal_read";
    step(0, 0, oh(DEF), 0, 0, 0, 12'h123);
    step(0, 11'h000, 0, 0, 0, 0, 0);
    step(0, 11'h003, 0, 0, 0, 0, 0);
    step(0, 11'h7FF, 0, 0, 0, 0, 0);

    phase = "reset_mid";
    step(0, 0, oh(0), 0, 0, 0, 12'hABC);
    step(0, oh(0), oh(5), 0, 0, 0, 12'h555);
    step(0, oh(0), 0, 0, 1, 0, 12'hFFF);
    step(1, oh(0), 11'h001, 11'h002, 1, 0, 12'h777);
    for (int i = 0; i < N; i++) step(0, oh(i), 0, 0, 0, 0, 0);

    phase = "random";
    for (int n = 0; n < 600; n++) begin
      r_rd  = ($urandom_range(0, 7) == 0) ? N'($urandom) : oh($urandom_range(0, N - 1));
      r_wr  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      r_inc = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      step($urandom_range(0, 63) == 0, r_rd, r_wr, r_inc,
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
           int'($urandom_range(0, (1 << W) - 1)));
    end

    phase = "drain";
    @(posedge clk);
    #1;
    bus.write_en = '0;
    bus.inc_en   = '0;
    bus.acc_en   = 1'b0;
    bus.clr_ovf  = 1'b0;
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
